// File: rtl/rfmt_control_sequencer.sv
// Control FSM that sequences one R-format instruction (fetch, memory handshake,
// decode, ALU execute and write-back, including two-result MUL/DIV) on the shared-bus datapath.
module rfmt_control_sequencer #(
    parameter int         NUM_REGS   = 16,
    parameter logic [4:0] MAX_ALU_OP = 5'b01100,
    parameter logic [4:0] MUL_OP     = 5'b01111,
    parameter logic [4:0] DIV_OP     = 5'b10000
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                start,
    input  logic                mem_ready,
    input  logic [31:0]         ir,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic                PCout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zlowin,
    output logic                Zhighin,
    output logic                ZLOout,
    output logic                ZHIout,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                read,
    output logic [4:0]          operation,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_T3, S_T4, S_T5, S_T6, S_FIN
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [4:0] opcode_q;
    logic [3:0] ra_q;
    logic [3:0] rb_q;
    logic [3:0] rc_q;
    logic [4:0] op_hold_q;

    logic [4:0] ir_op;
    logic [3:0] ir_ra;
    logic [3:0] ir_rb;
    logic [3:0] ir_rc;
    logic       dec_legal;
    logic       is_muldiv;
    logic       rout_b_en;
    logic       rout_c_en;
    logic       rin_a_en;
    logic       unused_ir;

    assign ir_op     = ir[31:27];
    assign ir_ra     = ir[26:23];
    assign ir_rb     = ir[22:19];
    assign ir_rc     = ir[18:15];
    assign unused_ir = ^ir[14:0];

    // Legality is judged on the live IR in DEC, since the field registers load on that same edge.
    assign dec_legal = ((ir_op <= MAX_ALU_OP) || (ir_op == MUL_OP) || (ir_op == DIV_OP))
                       && ({1'b0, ir_ra} < 5'(NUM_REGS))
                       && ({1'b0, ir_rb} < 5'(NUM_REGS))
                       && ({1'b0, ir_rc} < 5'(NUM_REGS));

    assign is_muldiv = (opcode_q == MUL_OP) || (opcode_q == DIV_OP);
    assign operation = op_hold_q;

    function automatic logic [NUM_REGS-1:0] reg_select(input logic [3:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (idx == 4'(i));
        end
        return v;
    endfunction

    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= S_IDLE;
            opcode_q  <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            op_hold_q <= '0;
        end else begin
            state <= state_next;
            if (state == S_DEC) begin
                opcode_q <= ir_op;
                ra_q     <= ir_ra;
                rb_q     <= ir_rb;
                rc_q     <= ir_rc;
            end
            // Loaded on entry to T4 so the ALU select is stable for the whole execute cycle and after.
            if (state == S_T3) begin
                op_hold_q <= opcode_q;
            end
        end
    end

    always_comb begin
        state_next = state;
        PCout      = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        ZLOout     = 1'b0;
        ZHIout     = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        IncPC      = 1'b0;
        read       = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        rout_b_en  = 1'b0;
        rout_c_en  = 1'b0;
        rin_a_en   = 1'b0;
        busy       = (state != S_IDLE);

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_T0;
                end
            end
            S_T0: begin
                PCout      = 1'b1;
                MARin      = 1'b1;
                IncPC      = 1'b1;
                Zlowin     = 1'b1;
                state_next = S_T1;
            end
            S_T1: begin
                read  = 1'b1;
                MDRin = 1'b1;
                if (mem_ready) begin
                    ZLOout     = 1'b1;
                    PCin       = 1'b1;
                    state_next = S_T2;
                end
            end
            S_T2: begin
                MDRout     = 1'b1;
                IRin       = 1'b1;
                state_next = S_DEC;
            end
            S_DEC: begin
                if (dec_legal) begin
                    state_next = S_T3;
                end else begin
                    illegal    = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_T3: begin
                rout_b_en  = 1'b1;
                Yin        = 1'b1;
                state_next = S_T4;
            end
            S_T4: begin
                rout_c_en  = 1'b1;
                Zlowin     = 1'b1;
                Zhighin    = is_muldiv;
                state_next = S_T5;
            end
            S_T5: begin
                ZLOout = 1'b1;
                if (is_muldiv) begin
                    LOin       = 1'b1;
                    state_next = S_T6;
                end else begin
                    rin_a_en   = 1'b1;
                    state_next = S_FIN;
                end
            end
            S_T6: begin
                ZHIout     = 1'b1;
                HIin       = 1'b1;
                state_next = S_FIN;
            end
            S_FIN: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Rout = '0;
        Rin  = '0;
        if (rout_b_en) begin
            Rout = reg_select(rb_q);
        end else if (rout_c_en) begin
            Rout = reg_select(rc_q);
        end
        if (rin_a_en) begin
            Rin = reg_select(ra_q);
        end
    end

endmodule

// File: tb/tb_rfmt_control_sequencer.sv
// Scoreboard bench: each instruction is expanded into per-cycle expected control words,
// queued, then driven and compared cycle by cycle against the sequencer outputs.
module tb_rfmt_control_sequencer;

    typedef struct packed {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [4:0]  operation;
        logic pcout, pcin, marin, mdrin, mdrout, irin, yin, zlowin, zhighin;
        logic zloout, zhiout, hiin, loin, incpc, rd, busy, done, illegal;
    } ctl_t;

    typedef struct {
        ctl_t  exp;
        logic  mr;
        logic  st;
        logic  clr;
        string tag;
    } entry_t;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;

    logic [15:0] Rout, Rin;
    logic PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
    logic ZLOout, ZHIout, HIin, LOin, IncPC, read, busy, done, illegal;
    logic [4:0] operation;

    logic [7:0] Rout8, Rin8;
    logic PCout8, PCin8, MARin8, MDRin8, MDRout8, IRin8, Yin8, Zlowin8, Zhighin8;
    logic ZLOout8, ZHIout8, HIin8, LOin8, IncPC8, read8, busy8, done8, illegal8;
    logic [4:0] operation8;

    int         checks = 0;
    int         errors = 0;
    logic [4:0] model_op = 5'd0;
    entry_t     sb[$];

    string cur_name;
    int    cur_idx;
    int    cur_s1;
    int    cur_s2;
    int    cur_clr;
    bit    aborted;

    int ill8_cnt;
    int ill8_cyc;
    int yin8_cnt;
    int rin8_cnt;

    always #5 clock = ~clock;

    rfmt_control_sequencer #(.NUM_REGS(16)) dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .Rout(Rout), .Rin(Rin), .PCout(PCout), .PCin(PCin), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin),
        .Zhighin(Zhighin), .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .read(read), .operation(operation), .busy(busy), .done(done),
        .illegal(illegal)
    );

    rfmt_control_sequencer #(.NUM_REGS(8)) dut8 (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
        .Rout(Rout8), .Rin(Rin8), .PCout(PCout8), .PCin(PCin8), .MARin(MARin8),
        .MDRin(MDRin8), .MDRout(MDRout8), .IRin(IRin8), .Yin(Yin8), .Zlowin(Zlowin8),
        .Zhighin(Zhighin8), .ZLOout(ZLOout8), .ZHIout(ZHIout8), .HIin(HIin8), .LOin(LOin8),
        .IncPC(IncPC8), .read(read8), .operation(operation8), .busy(busy8), .done(done8),
        .illegal(illegal8)
    );

    function automatic ctl_t observe();
        ctl_t c;
        c.rout = Rout;     c.rin = Rin;       c.operation = operation;
        c.pcout = PCout;   c.pcin = PCin;     c.marin = MARin;     c.mdrin = MDRin;
        c.mdrout = MDRout; c.irin = IRin;     c.yin = Yin;         c.zlowin = Zlowin;
        c.zhighin = Zhighin; c.zloout = ZLOout; c.zhiout = ZHIout; c.hiin = HIin;
        c.loin = LOin;     c.incpc = IncPC;   c.rd = read;         c.busy = busy;
        c.done = done;     c.illegal = illegal;
        return c;
    endfunction

    function automatic ctl_t base(input bit is_busy);
        ctl_t c;
        c = '0;
        c.operation = model_op;
        c.busy = is_busy;
        return c;
    endfunction

    function automatic logic [15:0] bit16(input int i);
        return 16'(1) << i;
    endfunction

    task automatic check_ctl(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input ctl_t c, input logic mr);
        entry_t e;
        if (aborted) return;
        e.exp = c;
        e.mr  = mr;
        e.st  = (cur_idx == 0) || (cur_idx == cur_s1) || (cur_idx == cur_s2);
        e.clr = (cur_idx == cur_clr);
        e.tag = $sformatf("%s_c%0d", cur_name, cur_idx);
        sb.push_back(e);
        if (e.clr) begin
            aborted  = 1'b1;
            model_op = 5'd0;
            e.exp = base(1'b0);
            e.st  = 1'b0;
            e.clr = 1'b0;
            e.tag = $sformatf("%s_after_clear", cur_name);
            sb.push_back(e);
        end
        cur_idx++;
    endtask

    // Expands one instruction into its expected cycle-by-cycle control words.
    task automatic applyStimulus(input string name, input logic [31:0] instr, input int waits,
                                 input int s1, input int s2, input int clr_at);
        ctl_t       c;
        logic [4:0] op;
        int         ra, rb, rc;
        bit         legal, md;
        op = instr[31:27];
        ra = int'(instr[26:23]);
        rb = int'(instr[22:19]);
        rc = int'(instr[18:15]);
        legal = (op <= 5'd12) || (op == 5'd15) || (op == 5'd16);
        md    = (op == 5'd15) || (op == 5'd16);
        cur_name = name; cur_idx = 0; cur_s1 = s1; cur_s2 = s2; cur_clr = clr_at; aborted = 1'b0;

        c = base(1'b0); push_entry(c, 1'b1);
        c = base(1'b1); c.pcout = 1; c.marin = 1; c.incpc = 1; c.zlowin = 1; push_entry(c, 1'b1);
        for (int w = 0; w < waits; w++) begin
            c = base(1'b1); c.rd = 1; c.mdrin = 1; push_entry(c, 1'b0);
        end
        c = base(1'b1); c.rd = 1; c.mdrin = 1; c.zloout = 1; c.pcin = 1; push_entry(c, 1'b1);
        c = base(1'b1); c.mdrout = 1; c.irin = 1; push_entry(c, 1'b1);
        c = base(1'b1); c.illegal = !legal; push_entry(c, 1'b1);
        if (legal) begin
            c = base(1'b1); c.rout = bit16(rb); c.yin = 1; push_entry(c, 1'b1);
            if (!aborted) model_op = op;
            c = base(1'b1); c.rout = bit16(rc); c.zlowin = 1; c.zhighin = md; push_entry(c, 1'b1);
            if (md) begin
                c = base(1'b1); c.zloout = 1; c.loin = 1; push_entry(c, 1'b1);
                c = base(1'b1); c.zhiout = 1; c.hiin = 1; push_entry(c, 1'b1);
            end else begin
                c = base(1'b1); c.zloout = 1; c.rin = bit16(ra); push_entry(c, 1'b1);
            end
            c = base(1'b1); c.done = 1; push_entry(c, 1'b1);
        end
        c = base(1'b0); push_entry(c, 1'b1);
    endtask

    // Drains the scoreboard: drive each cycle's inputs, then compare outputs and invariants.
    task automatic checkOutput();
        entry_t e;
        int     cyc;
        cyc = 0;
        ill8_cnt = 0; ill8_cyc = -1; yin8_cnt = 0; rin8_cnt = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            mem_ready = e.mr;
            start     = e.st;
            clear     = e.clr;
            #1;
            check_ctl(e.tag, observe(), e.exp);
            checks++;
            assert ($onehot0(Rout) && $onehot0(Rin) &&
                    ($countones({|Rout, PCout, MDRout, ZLOout, ZHIout}) <= 1)) else begin
                errors++;
                $error("[TB] FAIL invariant_%s observed Rout=%h Rin=%h drivers=%b expected one-hot0",
                       e.tag, Rout, Rin, {|Rout, PCout, MDRout, ZLOout, ZHIout});
            end
            if (illegal8) begin ill8_cnt++; ill8_cyc = cyc; end
            if (Yin8) yin8_cnt++;
            if (|Rin8) rin8_cnt++;
            @(posedge clock);
            #1;
            cyc++;
        end
        start = 1'b0;
        clear = 1'b0;
        mem_ready = 1'b1;
    endtask

    initial begin
        entry_t e;
        clear = 1'b1;
        start = 1'b0;
        mem_ready = 1'b1;
        ir = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_ctl("reset", observe(), ctl_t'(0));
        clear = 1'b0;

        ir = 32'h389A8000;
        applyStimulus("shr", ir, 0, -1, -1, -1);
        checkOutput();

        applyStimulus("shr_wait3", ir, 3, -1, -1, -1);
        checkOutput();

        ir = {5'b01111, 4'd0, 4'd2, 4'd4, 15'd0};
        applyStimulus("mul", ir, 0, -1, -1, -1);
        checkOutput();

        ir = {5'b10000, 4'd6, 4'd7, 4'd8, 15'h1234};
        applyStimulus("div_wait1", ir, 1, -1, -1, -1);
        checkOutput();

        // Simultaneous clear and start from IDLE: clear wins and operation returns to 0.
        e.exp = base(1'b0); e.mr = 1'b1; e.st = 1'b1; e.clr = 1'b1; e.tag = "clr_start_c0";
        sb.push_back(e);
        model_op = 5'd0;
        e.exp = base(1'b0); e.st = 1'b0; e.clr = 1'b0; e.tag = "clr_start_c1";
        sb.push_back(e);
        checkOutput();

        ir = {5'b11111, 4'd1, 4'd2, 4'd3, 15'd0};
        applyStimulus("illegal_op", ir, 0, -1, -1, -1);
        checkOutput();

        ir = {5'b01101, 4'd1, 4'd2, 4'd3, 15'd0};
        applyStimulus("op13_illegal", ir, 0, -1, -1, -1);
        checkOutput();

        ir = {5'b01100, 4'd15, 4'd15, 4'd0, 15'd0};
        applyStimulus("op12_edge", ir, 0, -1, -1, -1);
        checkOutput();

        ir = {5'b00011, 4'd1, 4'd2, 4'd9, 15'd0};
        applyStimulus("rc9", ir, 0, -1, -1, -1);
        checkOutput();
        check_int("n8_illegal_count", ill8_cnt, 1);
        check_int("n8_illegal_cycle", ill8_cyc, 4);
        check_int("n8_yin_count", yin8_cnt, 0);
        check_int("n8_rin_count", rin8_cnt, 0);
        check_int("n8_busy_end", int'(busy8), 0);

        ir = 32'h389A8000;
        applyStimulus("abort_t4", ir, 0, -1, -1, 6);
        checkOutput();

        applyStimulus("after_abort", ir, 0, -1, -1, -1);
        checkOutput();

        ir = {5'b00101, 4'd9, 4'd10, 4'd11, 15'd0};
        applyStimulus("busy_start", ir, 0, 3, 7, -1);
        checkOutput();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
